// File: rtl/timer.sv
// DMG-style timer/divider: free-running 16-bit system counter (DIV), TIMA/TMA/TAC
// registers on the CPU bus, TIMA overflow reload and level timer interrupt request.
module timer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] A,
  input  logic [7:0]  Di,
  output logic [7:0]  Do,
  input  logic        wr_n,
  input  logic        rd_n,
  input  logic        cs,
  output logic        int_req,
  input  logic        int_ack
);

  localparam logic [15:0] DIV_ADDR  = 16'hFF04;
  localparam logic [15:0] TIMA_ADDR = 16'hFF05;
  localparam logic [15:0] TMA_ADDR  = 16'hFF06;
  localparam logic [15:0] TAC_ADDR  = 16'hFF07;

  logic [15:0] sys_cnt_q, sys_cnt_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic        tick_d_q;
  logic        int_req_q, int_req_d;
  logic [7:0]  rdata_q, rdata_d;

  logic wr_en, rd_en;
  logic wr_div, wr_tima, wr_tma, wr_tac;
  logic tick_sel, tick_in, tick_fall, overflow;

  // A simultaneous read and write is treated as a write only.
  assign wr_en   = cs & ~wr_n;
  assign rd_en   = cs & ~rd_n & wr_n;
  assign wr_div  = wr_en & (A == DIV_ADDR);
  assign wr_tima = wr_en & (A == TIMA_ADDR);
  assign wr_tma  = wr_en & (A == TMA_ADDR);
  assign wr_tac  = wr_en & (A == TAC_ADDR);

  always_comb begin
    unique case (tac_q[1:0])
      2'b00:   tick_sel = sys_cnt_q[9];
      2'b01:   tick_sel = sys_cnt_q[3];
      2'b10:   tick_sel = sys_cnt_q[5];
      default: tick_sel = sys_cnt_q[7];
    endcase
  end

  // Pure falling-edge detect: DIV resets and TAC changes can also produce an increment.
  assign tick_in   = tick_sel & tac_q[2];
  assign tick_fall = tick_d_q & ~tick_in;

  always_comb begin
    sys_cnt_d = wr_div ? 16'h0000 : sys_cnt_q + 16'd1;
    tma_d     = wr_tma ? Di : tma_q;
    tac_d     = wr_tac ? Di[2:0] : tac_q;
    tima_d    = tima_q;
    overflow  = 1'b0;
    if (wr_tima) begin
      tima_d = Di;
    end else if (tick_fall) begin
      if (tima_q == 8'hFF) begin
        tima_d   = tma_d;
        overflow = 1'b1;
      end else begin
        tima_d = tima_q + 8'd1;
      end
    end
  end

  always_comb begin
    int_req_d = int_req_q;
    if (overflow) begin
      int_req_d = 1'b1;
    end else if (int_ack) begin
      int_req_d = 1'b0;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      unique case (A)
        DIV_ADDR:  rdata_d = sys_cnt_q[15:8];
        TIMA_ADDR: rdata_d = tima_q;
        TMA_ADDR:  rdata_d = tma_q;
        TAC_ADDR:  rdata_d = {5'b11111, tac_q};
        default:   rdata_d = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sys_cnt_q <= 16'h0000;
      tima_q    <= 8'h00;
      tma_q     <= 8'h00;
      tac_q     <= 3'b000;
      tick_d_q  <= 1'b0;
      int_req_q <= 1'b0;
      rdata_q   <= 8'hFF;
    end else begin
      sys_cnt_q <= sys_cnt_d;
      tima_q    <= tima_d;
      tma_q     <= tma_d;
      tac_q     <= tac_d;
      tick_d_q  <= tick_in;
      int_req_q <= int_req_d;
      rdata_q   <= rdata_d;
    end
  end

  assign Do      = cs ? rdata_q : 8'hFF;
  assign int_req = int_req_q;

endmodule

// File: tb/tb_timer.sv
// Testbench for timer: directed scenarios plus random bus traffic, all checked
// cycle by cycle against an arithmetic reference model of the timer rules.
module tb_timer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [7:0]  Di = 8'h00;
  logic [7:0]  Do;
  logic        wr_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        cs = 1'b0;
  logic        int_req;
  logic        int_ack = 1'b0;

  always #5 clock = ~clock;

  timer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .A       (A),
    .Di      (Di),
    .Do      (Do),
    .wr_n    (wr_n),
    .rd_n    (rd_n),
    .cs      (cs),
    .int_req (int_req),
    .int_ack (int_ack)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_cnt, m_tima, m_tma, m_tac, m_rd;
  bit m_prev_tick, m_int;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rate_bit(input int tac);
    case (tac % 4)
      0: return 9;
      1: return 3;
      2: return 5;
      default: return 7;
    endcase
  endfunction

  function automatic bit m_tick();
    return ((m_tac / 4) % 2 == 1) && (((m_cnt >> rate_bit(m_tac)) % 2) == 1);
  endfunction

  function automatic bit m_fall();
    return m_prev_tick && !m_tick();
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_rd = 255;
    m_prev_tick = 0; m_int = 0;
  endtask

  // One clock: predict next state from current inputs, clock, then compare.
  task automatic step();
    int n_cnt, n_tima, n_tma, n_tac, n_rd;
    bit n_int, do_wr, do_rd, ovf;
    n_cnt = m_cnt; n_tima = m_tima; n_tma = m_tma; n_tac = m_tac; n_rd = m_rd; n_int = m_int;
    ovf = 0;
    do_wr = cs && !wr_n;
    do_rd = cs && !rd_n && wr_n;
    if (reset_n) begin
      n_cnt = (do_wr && A == 16'hFF04) ? 0 : (m_cnt + 1) % 65536;
      if (do_wr && A == 16'hFF06) n_tma = int'(Di);
      if (do_wr && A == 16'hFF07) n_tac = int'(Di) % 8;
      if (do_wr && A == 16'hFF05) n_tima = int'(Di);
      else if (m_fall()) begin
        if (m_tima == 255) begin n_tima = n_tma; ovf = 1; end
        else n_tima = m_tima + 1;
      end
      if (ovf) n_int = 1;
      else if (int_ack) n_int = 0;
      if (do_rd) begin
        case (A)
          16'hFF04: n_rd = m_cnt / 256;
          16'hFF05: n_rd = m_tima;
          16'hFF06: n_rd = m_tma;
          16'hFF07: n_rd = 248 + m_tac;
          default:  n_rd = 255;
        endcase
      end
    end
    @(posedge clock);
    #1;
    if (reset_n) begin
      m_prev_tick = m_tick();
      m_cnt = n_cnt; m_tima = n_tima; m_tma = n_tma; m_tac = n_tac; m_rd = n_rd; m_int = n_int;
    end else begin
      model_reset();
    end
    check("do", {8'h00, Do}, cs ? 16'(m_rd) : 16'h00FF);
    check("int_req", {15'h0, int_req}, {15'h0, m_int});
  endtask

  task automatic bus_off();
    cs = 0; wr_n = 1; rd_n = 1; int_ack = 0;
  endtask

  task automatic idle(input int n);
    bus_off();
    repeat (n) step();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cs = 1; A = a; Di = d; wr_n = 0; rd_n = 1;
    step();
    bus_off();
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] v);
    cs = 1; A = a; wr_n = 1; rd_n = 0;
    step();
    v = Do;
    bus_off();
  endtask

  task automatic wait_mod16(input int v);
    int k;
    k = 0;
    while ((m_cnt % 16) != v && k < 64) begin idle(1); k++; end
    if (k >= 64) check("wait_mod16_timeout", 16'(k), 16'(0));
  endtask

  task automatic wait_fall();
    int k;
    k = 0;
    while (!m_fall() && k < 2000) begin idle(1); k++; end
    if (k >= 2000) check("wait_fall_timeout", 16'(k), 16'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int k;
    model_reset();
    #22;
    @(posedge clock); #1;
    reset_n = 1;

    // reset values
    idle(1);
    check("cs0_do", {8'h00, Do}, 16'h00FF);
    rd(16'hFF04, v); check("rst_div", {8'h00, v}, 16'h0000);
    rd(16'hFF05, v); check("rst_tima", {8'h00, v}, 16'h0000);
    rd(16'hFF06, v); check("rst_tma", {8'h00, v}, 16'h0000);
    rd(16'hFF07, v); check("rst_tac", {8'h00, v}, 16'h00F8);
    rd(16'hFF10, v); check("rd_other", {8'h00, v}, 16'h00FF);

    // DIV counting and reset-on-write
    wr(16'hFF04, 8'h5A);
    idle(512);
    rd(16'hFF04, v); check("div_512", {8'h00, v}, 16'h0002);
    wr(16'hFF04, 8'h5A);
    rd(16'hFF04, v); check("div_clr", {8'h00, v}, 16'h0000);

    // overflow reload and interrupt
    wr(16'hFF07, 8'h05);
    wr(16'hFF06, 8'hF0);
    wr(16'hFF05, 8'hFE);
    k = 0; v = 8'h00;
    while (v != 8'hFF && k < 20) begin rd(16'hFF05, v); k++; end
    check("tima_ff", {8'h00, v}, 16'h00FF);
    k = 0;
    while (v != 8'hF0 && k < 20) begin rd(16'hFF05, v); k++; end
    check("tima_reload", {8'h00, v}, 16'h00F0);
    check("irq_set", {15'h0, int_req}, 16'h0001);
    idle(100);
    check("irq_hold", {15'h0, int_req}, 16'h0001);
    int_ack = 1; step(); int_ack = 0;
    check("irq_ack", {15'h0, int_req}, 16'h0000);

    // TIMA write on the overflow edge wins
    wr(16'hFF05, 8'hFF);
    wait_fall();
    wr(16'hFF05, 8'h33);
    rd(16'hFF05, v); check("ovf_wr_tima", {8'h00, v}, 16'h0033);
    check("ovf_wr_irq", {15'h0, int_req}, 16'h0000);

    // TMA write on the overflow edge feeds the reload
    wr(16'hFF05, 8'hFF);
    wait_fall();
    wr(16'hFF06, 8'h77);
    rd(16'hFF05, v); check("ovf_wr_tma", {8'h00, v}, 16'h0077);
    check("ovf_tma_irq", {15'h0, int_req}, 16'h0001);
    int_ack = 1; step(); int_ack = 0;

    // falling-edge glitches from DIV writes and TAC changes
    wait_mod16(7); wr(16'hFF05, 8'h10); wr(16'hFF04, 8'h00); idle(1);
    rd(16'hFF05, v); check("div_glitch", {8'h00, v}, 16'h0011);
    wait_mod16(1); wr(16'hFF05, 8'h20); wr(16'hFF04, 8'h00); idle(1);
    rd(16'hFF05, v); check("div_noglitch", {8'h00, v}, 16'h0020);
    wait_mod16(7); wr(16'hFF05, 8'h30); wr(16'hFF07, 8'h01); idle(1);
    rd(16'hFF05, v); check("tac_glitch", {8'h00, v}, 16'h0031);

    // ack on the overflow edge: set wins
    wr(16'hFF07, 8'h05);
    wr(16'hFF05, 8'hFF);
    wait_fall();
    int_ack = 1; step(); int_ack = 0;
    check("ack_vs_set", {15'h0, int_req}, 16'h0001);

    // asynchronous reset mid-count
    cs = 1; A = 16'hFF05; rd_n = 0; wr_n = 1;
    repeat (5) step();
    #3;
    reset_n = 0;
    #1;
    model_reset();
    check("arst_do", {8'h00, Do}, 16'h00FF);
    check("arst_irq", {15'h0, int_req}, 16'h0000);
    idle(3);
    reset_n = 1;
    idle(40);
    rd(16'hFF05, v); check("arst_tima", {8'h00, v}, 16'h0000);
    rd(16'hFF07, v); check("arst_tac", {8'h00, v}, 16'h00F8);

    // random bus traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cs = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) A = 16'hFF00 + 16'($urandom_range(0, 15));
      else A = 16'hFF04 + 16'($urandom_range(0, 3));
      wr_n = ($urandom_range(0, 3) != 0);
      rd_n = ($urandom_range(0, 1) != 0);
      Di = 8'($urandom);
      if (A == 16'hFF07 && $urandom_range(0, 1) == 1) Di[2] = 1'b1;
      if (A == 16'hFF05 && $urandom_range(0, 1) == 1) Di = 8'hFD;
      int_ack = ($urandom_range(0, 7) == 0);
      step();
    end
    bus_off();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
